// File: rtl/display_segundos.sv
// ============================================================================
// Module  : display_segundos
// Brief   : Seconds counter to 3-digit BCD (double-dabble FSM) + 7-seg scanner
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_segundos #(
  parameter int SCAN_DIV = 27000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] segundos,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic [3:0] unidades,
  output logic [3:0] decenas,
  output logic [3:0] centenas,
  output logic       bcd_valid,
  output logic       busy
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_conv = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;
  localparam int         c_presc_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [7:0]           r_last_val;
  logic [19:0]          r_shift;
  logic [19:0]          w_adj;
  logic [2:0]           r_bitcnt;
  logic                 w_start;
  logic [c_presc_w-1:0] r_presc;
  logic                 w_wrap;
  logic [1:0]           r_idx;
  logic [1:0]           w_idx_nxt;
  logic [3:0]           w_digit;
  logic                 w_blank;
  logic [2:0]           w_an_nxt;

  function automatic logic [3:0] nib_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_rom(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  assign w_start = (r_state == c_st_idle) && (segundos != r_last_val);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_start) w_state_nxt = c_st_conv;
      c_st_conv: if (r_bitcnt == 3'd7) w_state_nxt = c_st_done;
      c_st_done: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (r_state == c_st_conv) || (r_state == c_st_done);
  end

  // Upper 12 bits hold the BCD nibbles, lower 8 bits the binary being shifted out
  always_comb begin
    w_adj        = r_shift;
    w_adj[11:8]  = nib_adj(r_shift[11:8]);
    w_adj[15:12] = nib_adj(r_shift[15:12]);
    w_adj[19:16] = nib_adj(r_shift[19:16]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_val <= 8'd0;
      r_shift    <= 20'd0;
      r_bitcnt   <= 3'd0;
      unidades   <= 4'd0;
      decenas    <= 4'd0;
      centenas   <= 4'd0;
      bcd_valid  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (w_start) begin
        r_shift    <= {12'd0, segundos};
        r_last_val <= segundos;
        r_bitcnt   <= 3'd0;
      end else if (r_state == c_st_conv) begin
        r_shift  <= {w_adj[18:0], 1'b0};
        r_bitcnt <= r_bitcnt + 3'd1;
      end else if (r_state == c_st_done) begin
        centenas  <= r_shift[19:16];
        decenas   <= r_shift[15:12];
        unidades  <= r_shift[11:8];
        bcd_valid <= 1'b1;
      end
    end
  end

  assign w_wrap    = (r_presc == c_presc_w'(SCAN_DIV - 1));
  assign w_idx_nxt = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;

  // Select the digit for the slot about to be shown, with leading-zero blanking
  always_comb begin
    w_digit  = unidades;
    w_blank  = 1'b0;
    w_an_nxt = 3'b110;
    case (w_idx_nxt)
      2'd1: begin
        w_digit  = decenas;
        w_blank  = (centenas == 4'd0) && (decenas == 4'd0);
        w_an_nxt = 3'b101;
      end
      2'd2: begin
        w_digit  = centenas;
        w_blank  = (centenas == 4'd0);
        w_an_nxt = 3'b011;
      end
      default: begin
        w_digit  = unidades;
        w_blank  = 1'b0;
        w_an_nxt = 3'b110;
      end
    endcase
  end

  // seg/an only change on a scan step, so a mid-period digit update cannot glitch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      seg     <= 7'b1111110;
      an      <= 3'b110;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_idx   <= w_idx_nxt;
      seg     <= w_blank ? 7'b0000000 : seg_rom(w_digit);
      an      <= w_blank ? 3'b111 : w_an_nxt;
    end else begin
      r_presc <= r_presc + c_presc_w'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_segundos.sv
// ============================================================================
// Module  : tb_display_segundos
// Brief   : Directed self-checking bench for display_segundos (SCAN_DIV = 4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_segundos;

  localparam int c_div = 4;

  logic       clk;
  logic       reset;
  logic [7:0] segundos;
  logic [6:0] seg;
  logic [2:0] an;
  logic [3:0] unidades;
  logic [3:0] decenas;
  logic [3:0] centenas;
  logic       bcd_valid;
  logic       busy;

  int n_assert;
  int n_fail;
  int pulses;

  display_segundos #(.SCAN_DIV(c_div)) dut (
    .clk       (clk),
    .reset     (reset),
    .segundos  (segundos),
    .seg       (seg),
    .an        (an),
    .unidades  (unidades),
    .decenas   (decenas),
    .centenas  (centenas),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Locate the start of a units period, then check every cycle of one full scan round
  task automatic scan_check(input string tag,
                            input logic [6:0] s0, input logic [2:0] a0,
                            input logic [6:0] s1, input logic [2:0] a1,
                            input logic [6:0] s2, input logic [2:0] a2);
    logic [2:0] prev;
    logic       found;
    prev  = an;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (an == 3'b110 && prev != 3'b110) found = 1'b1;
      prev = an;
    end
    chk({tag, "_sync"}, found, 1'b1);
    for (int k = 0; k < 3 * c_div; k++) begin
      if (k != 0) tick();
      case (k / c_div)
        0: begin chk({tag, "_seg_u"}, seg, s0); chk({tag, "_an_u"}, an, a0); end
        1: begin chk({tag, "_seg_d"}, seg, s1); chk({tag, "_an_d"}, an, a1); end
        default: begin chk({tag, "_seg_c"}, seg, s2); chk({tag, "_an_c"}, an, a2); end
      endcase
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    segundos = 8'd0;
    repeat (3) tick();
    chk("rst_an", an, 3'b110);
    chk("rst_seg", seg, 7'b1111110);
    chk("rst_u", unidades, 4'd0);
    chk("rst_d", decenas, 4'd0);
    chk("rst_c", centenas, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", bcd_valid, 1'b0);

    // Zero held: nothing to convert, only units lit
    reset = 1'b0;
    repeat (5) begin
      tick();
      chk("zero_busy", busy, 1'b0);
      chk("zero_valid", bcd_valid, 1'b0);
    end
    scan_check("zero", 7'b1111110, 3'b110, 7'b0000000, 3'b111, 7'b0000000, 3'b111);

    // 255: busy for E0..E8, pulse at E9
    segundos = 8'd255;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("255_busy", busy, 1'b1);
      chk("255_novalid", bcd_valid, 1'b0);
    end
    tick();
    chk("255_valid", bcd_valid, 1'b1);
    chk("255_busy_end", busy, 1'b0);
    chk("255_c", centenas, 4'd2);
    chk("255_d", decenas, 4'd5);
    chk("255_u", unidades, 4'd5);
    tick();
    chk("255_valid_off", bcd_valid, 1'b0);
    scan_check("255", 7'b1011011, 3'b110, 7'b1011011, 3'b101, 7'b1101101, 3'b011);

    // 60: hundreds blanked, tens not
    segundos = 8'd60;
    repeat (10) tick();
    chk("60_valid", bcd_valid, 1'b1);
    chk("60_c", centenas, 4'd0);
    chk("60_d", decenas, 4'd6);
    chk("60_u", unidades, 4'd0);
    scan_check("60", 7'b1111110, 3'b110, 7'b1011111, 3'b101, 7'b0000000, 3'b111);

    // 135, changed to 225 while converting; second conversion starts at E10
    segundos = 8'd135;
    pulses   = 0;
    for (int i = 0; i <= 30; i++) begin
      tick();
      if (bcd_valid) pulses++;
      if (i == 2) segundos = 8'd225;
      if (i == 9) begin
        chk("135_valid", bcd_valid, 1'b1);
        chk("135_c", centenas, 4'd1);
        chk("135_d", decenas, 4'd3);
        chk("135_u", unidades, 4'd5);
      end
      if (i == 10) chk("225_start_busy", busy, 1'b1);
      if (i == 19) begin
        chk("225_valid", bcd_valid, 1'b1);
        chk("225_c", centenas, 4'd2);
        chk("225_d", decenas, 4'd2);
        chk("225_u", unidades, 4'd5);
      end
    end
    chk("two_pulses", pulses, 2);

    // 99 aborted by reset at E5, then reconverted after release
    segundos = 8'd99;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", bcd_valid, 1'b0);
    chk("abort_an", an, 3'b110);
    chk("abort_seg", seg, 7'b1111110);
    chk("abort_c", centenas, 4'd0);
    chk("abort_d", decenas, 4'd0);
    chk("abort_u", unidades, 4'd0);
    repeat (3) begin
      tick();
      chk("abort_hold_valid", bcd_valid, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("99_busy", busy, 1'b1);
      chk("99_novalid", bcd_valid, 1'b0);
    end
    tick();
    chk("99_valid", bcd_valid, 1'b1);
    chk("99_c", centenas, 4'd0);
    chk("99_d", decenas, 4'd9);
    chk("99_u", unidades, 4'd9);
    scan_check("99", 7'b1111011, 3'b110, 7'b1111011, 3'b101, 7'b0000000, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_segundos.md
DISPLAY_SEGUNDOS -- requirements
Module: display_segundos

Interface
REQ-001 Parameter SCAN_DIV, default 27000, is the number of clk cycles each digit stays lit (1 kHz per digit at 27 MHz).
REQ-002 Port clk, input, 1 bit: single system clock (27 MHz); all state is clocked on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port segundos, input, 8 bits: binary elapsed-seconds count from the game timer, range 0..255.
REQ-005 Port seg, output, 7 bits: segment drive ordered {a,b,c,d,e,f,g} with a as MSB; active-high; registered.
REQ-006 Port an, output, 3 bits: digit enables, active-low one-hot; an[0] is units, an[1] is tens, an[2] is hundreds; registered.
REQ-007 Port unidades, decenas and centenas, outputs, 4 bits each: registered BCD digits of the last converted value.
REQ-008 Port bcd_valid, output, 1 bit: one-cycle pulse when the digit registers update.
REQ-009 Port busy, output, 1 bit: high while a conversion is in progress (states CONV and DONE).

Function
REQ-010 The converter SHALL be a 3-state FSM (IDLE, CONV, DONE) using iterative double-dabble: 8-bit binary in, 12-bit BCD out, one bit per clock.
REQ-011 IDLE SHALL compare segundos against an internal 8-bit last_val register on every clock.
REQ-012 When IDLE sees segundos != last_val (call this edge E0), the block SHALL load segundos into the shift register and into last_val, clear the bit counter and go to CONV.
REQ-013 On each of edges E1..E8, CONV SHALL perform one add-3 step (any BCD nibble >= 5 gets +3) followed by a left shift.
REQ-014 On E8, CONV SHALL go to DONE.
REQ-015 On E9, DONE SHALL write centenas, decenas and unidades, assert bcd_valid for exactly one cycle, and return to IDLE.
REQ-016 Conversion latency SHALL be exactly 9 clocks from the sampling edge to updated digit outputs.
REQ-017 While in CONV or DONE, segundos changes SHALL be ignored; on return to IDLE, a still-differing value SHALL start a new conversion on the next edge.
REQ-018 Digit outputs SHALL always be in the range 0..9; centenas SHALL be <= 2.
REQ-019 The scan prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-020 On each prescaler wrap, the scan index SHALL advance 0->1->2->0 (units -> tens -> hundreds -> units).
REQ-021 seg and an SHALL update on the same edge as the index change, from the current digit registers.
REQ-022 Segment ROM: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-023 Leading-zero blanking: the hundreds digit SHALL be blanked when centenas==0; the tens digit SHALL be blanked when centenas==0 and decenas==0; units SHALL never be blanked.
REQ-024 A blanked slot SHALL drive seg=0000000 and an=111 for that scan period.
REQ-025 If the digit registers update mid-period, the display SHALL show the new values from the next scan step onward; no glitch is permitted within a period.

Reset
REQ-026 While reset is high: state=IDLE, last_val=0, digits=0, bcd_valid=0, busy=0, prescaler=0, scan index=0, an=110, seg=1111110.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion with no bcd_valid pulse.
REQ-028 After reset release, a nonzero segundos SHALL start a conversion on the first clock edge.

Verification
REQ-029 Reset, then segundos=8'd0 held -> no conversion, busy=0; scan shows "0" on units, and tens/hundreds slots show an=111, seg=0000000.
REQ-030 segundos 0->8'd255 -> busy high for 9 clocks; bcd_valid pulses at E9; digits 2,5,5; scan displays 1101101, 1011011, 1011011 on an 011, 101, 110.
REQ-031 segundos=8'd60 -> digits 0,6,0; hundreds slot blanked; tens slot shows 1011111.
REQ-032 segundos=8'd135, then changed to 8'd225 at E3 -> first result 1,3,5; second conversion starts the edge after returning to IDLE; final digits 2,2,5; exactly two bcd_valid pulses.
REQ-033 With SCAN_DIV=4, reset asserted at E5 of a conversion of 8'd99 -> outputs return to reset values immediately, no bcd_valid; after release, reconversion yields 0,9,9; an sequence 110, 101, 111, repeating every 4 clocks per slot.
